// File: rtl/mul1024_slice_accumulator.sv
// Sequencer/accumulator for a 1024x1024 multiply: issues the multiplier one 32-bit
// slice at a time to a serial multiply stage and sums the shifted partial products.
module mul1024_slice_accumulator #(
  parameter int WORD_W    = 32,
  parameter int N_SLICES  = 32,
  parameter int SKIP_ZERO = 1
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            start,
  input  logic [WORD_W*N_SLICES-1:0]      a_in,
  input  logic [WORD_W*N_SLICES-1:0]      b_in,
  output logic [WORD_W*N_SLICES-1:0]      mcand,
  output logic [WORD_W-1:0]               slice,
  output logic                            slice_req,
  input  logic [WORD_W*(N_SLICES+1)-1:0]  pp_in,
  input  logic                            pp_valid,
  output logic                            busy,
  output logic                            done,
  output logic [2*WORD_W*N_SLICES-1:0]    product
);

  localparam int A_W   = WORD_W * N_SLICES;
  localparam int PP_W  = A_W + WORD_W;
  localparam int P_W   = 2 * A_W;
  localparam int IDX_W = $clog2(N_SLICES);
  localparam int SH_W  = IDX_W + $clog2(WORD_W);
  localparam bit SKIP  = (SKIP_ZERO != 0);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIN} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [A_W-1:0]     mcand_q;
  logic [A_W-1:0]     b_q;
  logic [WORD_W-1:0]  slice_q;
  logic               slice_req_q;
  logic               busy_q;
  logic               done_q;
  logic [P_W-1:0]     acc_q;
  logic [P_W-1:0]     product_q;

  logic [WORD_W-1:0]  cur_slice;
  logic [SH_W-1:0]    sh_amt;
  logic [P_W-1:0]     pp_shift;
  logic               last_idx;

  // WORD_W is a power of two, so idx*WORD_W is a plain concatenation.
  always_comb begin
    cur_slice = b_q[idx_q*WORD_W +: WORD_W];
    sh_amt    = {idx_q, {$clog2(WORD_W){1'b0}}};
    pp_shift  = {{(P_W-PP_W){1'b0}}, pp_in} << sh_amt;
    last_idx  = (idx_q == IDX_W'(N_SLICES-1));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      mcand_q     <= '0;
      b_q         <= '0;
      slice_q     <= '0;
      slice_req_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      acc_q       <= '0;
      product_q   <= '0;
    end else begin
      slice_req_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mcand_q <= a_in;
            b_q     <= b_in;
            acc_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (SKIP && cur_slice == '0) begin
            if (last_idx) state_q <= S_FIN;
            else          idx_q   <= idx_q + 1'b1;
          end else begin
            slice_q     <= cur_slice;
            slice_req_q <= 1'b1;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // No timeout: the serial stage is trusted to answer every request.
          if (pp_valid) begin
            acc_q <= acc_q + pp_shift;
            if (last_idx) begin
              state_q <= S_FIN;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= S_ISSUE;
            end
          end
        end
        S_FIN: begin
          product_q <= acc_q;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mcand     = mcand_q;
  assign slice     = slice_q;
  assign slice_req = slice_req_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign product   = product_q;

endmodule

// File: tb/tb_mul1024_slice_accumulator.sv
// Bench for mul1024_slice_accumulator: directed operands, a serial-stage responder
// model, and a scoreboard monitor that checks every slice_req and done.
module tb_mul1024_slice_accumulator;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [1023:0] a_in = '0;
  logic [1023:0] b_in = '0;
  logic [1023:0] mcand;
  logic [31:0]   slice;
  logic          slice_req;
  logic [1055:0] pp_in;
  logic          pp_valid;
  logic          busy;
  logic          done;
  logic [2047:0] product;

  logic          resp_valid = 1'b0;
  logic [1055:0] resp_pp = '0;
  logic          spur_valid = 1'b0;
  logic [1055:0] spur_pp = '0;

  assign pp_valid = resp_valid | spur_valid;
  assign pp_in    = resp_valid ? resp_pp : spur_pp;

  mul1024_slice_accumulator dut (
    .clk(clk), .rstn(rstn), .start(start), .a_in(a_in), .b_in(b_in),
    .mcand(mcand), .slice(slice), .slice_req(slice_req),
    .pp_in(pp_in), .pp_valid(pp_valid), .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail = 0;
  int            timeouts = 0;
  int            to_seen = 0;
  string         to_name = "";
  int            gen = 0;
  int            lat = 3;
  int            op_reqs = 0;
  time           t_acc = 0;
  logic [1023:0] cur_a = '0;

  logic [2047:0] prod_q[$];
  int            reqs_q[$];
  int            lat_q[$];
  logic [31:0]   slq[$];

  task automatic chk(input string nm, input logic [2047:0] act, input logic [2047:0] exp);
    int w;
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      w = 0;
      for (int i = 63; i >= 0; i--) if (act[32*i +: 32] !== exp[32*i +: 32]) w = i;
      $display("FAIL %s word %0d: got %h required %h", nm, w, act[32*w +: 32], exp[32*w +: 32]);
    end
  endtask

  // Monitor: all comparisons live here.
  initial begin
    logic [2047:0] ep;
    int            er, el, cyc;
    forever begin
      @(negedge clk);
      chk("timeout", 2048'(to_seen), 2048'(timeouts));
      to_seen = timeouts;
      if (!rstn) begin
        op_reqs = 0;
        chk("rst_ctl", {2045'b0, slice_req, busy, done}, '0);
        chk("rst_product", product, '0);
        chk("rst_mcand", {1024'b0, mcand}, '0);
        chk("rst_slice", {2016'b0, slice}, '0);
      end else begin
        if (slice_req) begin
          op_reqs++;
          if (slq.size() == 0) chk("unexpected_slice_req", 2048'(1), 2048'(0));
          else chk("slice", {2016'b0, slice}, {2016'b0, slq.pop_front()});
          chk("mcand", {1024'b0, mcand}, {1024'b0, cur_a});
        end
        if (done) begin
          if (prod_q.size() == 0) begin
            chk("spurious_done", 2048'(1), 2048'(0));
          end else begin
            ep = prod_q.pop_front();
            er = reqs_q.pop_front();
            el = lat_q.pop_front();
            chk("product", product, ep);
            chk("slice_req_count", 2048'(op_reqs), 2048'(er));
            chk("busy_at_done", {2047'b0, busy}, '0);
            if (el >= 0) begin
              cyc = int'((($time - t_acc) + 5) / 10) + 1;
              chk("done_latency", 2048'(cyc), 2048'(el));
            end
          end
          op_reqs = 0;
        end
      end
    end
  end

  // Serial multiply stage model: answers each slice_req lat cycles later with a*slice.
  initial begin
    int            g;
    logic [31:0]   s;
    logic [1023:0] a;
    forever begin
      @(negedge clk);
      if (rstn && slice_req) begin
        g = gen;
        s = slice;
        a = cur_a;
        repeat (lat) @(negedge clk);
        if (g == gen && rstn) begin
          resp_pp    = {32'b0, a} * {1024'b0, s};
          resp_valid = 1'b1;
          @(negedge clk);
          resp_valid = 1'b0;
        end
      end
    end
  end

  // Called at a negedge with the DUT idle; returns just after the accept edge.
  task automatic issue(input logic [1023:0] a, input logic [1023:0] b,
                       input logic [2047:0] exp, input int exp_lat);
    int n;
    logic [31:0] s;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      s = b[32*i +: 32];
      if (s != 0) begin slq.push_back(s); n++; end
    end
    cur_a = a;
    prod_q.push_back(exp);
    reqs_q.push_back(n);
    lat_q.push_back(exp_lat);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    t_acc = $time;
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n;
    n = 0;
    while (prod_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      to_name = nm;
      $display("FAIL wait_%s: no done within %0d cycles", nm, budget);
      timeouts++;
    end
    @(negedge clk);
  endtask

  logic [1023:0] ta;
  logic [1023:0] tb;
  logic [2047:0] te;

  initial begin
    int k;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // a=1, b=1 with a slow (34-cycle) serial stage
    lat = 34;
    issue(1024'd1, 1024'd1, 2048'd1, -1);
    wait_done("one", 200);
    lat = 3;

    // all-ones operands: every slice issued
    ta = '1;
    te = '1 - (2048'd1 << 1025) + 2048'd2;
    issue(ta, ta, te, -1);
    wait_done("ones", 1000);

    // zero multiplier: all slices skipped, done in cycle 35 counting the accept cycle as 1
    issue(1024'hABCD, 1024'd0, 2048'd0, 35);
    wait_done("zero", 100);

    // only slice 31 nonzero
    issue(1024'd3, 1024'd1 << 992, 2048'd3 << 992, -1);
    wait_done("top", 200);

    // start while busy and stray pp_valid in IDLE/ISSUE are ignored
    ta = (1024'd1 << 1023) + 1024'd12345;
    tb = (1024'd1 << 300) | (1024'd1 << 40) | 1024'hFF;
    te = ({1024'b0, ta} << 300) + ({1024'b0, ta} << 40) + ({1024'b0, ta} * 2048'd255);
    spur_pp = '1;
    spur_valid = 1'b1;
    @(negedge clk);
    spur_valid = 1'b0;
    issue(ta, tb, te, -1);
    @(negedge clk);
    spur_valid = 1'b1;
    @(negedge clk);
    spur_valid = 1'b0;
    repeat (3) @(negedge clk);
    a_in = '1;
    b_in = '1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done("ignore", 300);

    // reset while waiting on slice 5, then a fresh 5*7
    issue(1024'hDEAD_BEEF, '1, '0, -1);
    k = 0;
    for (int n = 0; n < 200 && k < 6; n++) begin
      @(negedge clk);
      if (slice_req) k++;
    end
    if (k < 6) begin
      to_name = "slice5";
      $display("FAIL wait_slice5: only %0d slice_req seen", k);
      timeouts++;
    end
    @(negedge clk);
    rstn = 1'b0;
    gen++;
    prod_q.delete();
    reqs_q.delete();
    lat_q.delete();
    slq.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    issue(1024'd5, 1024'd7, 2048'd35, -1);
    wait_done("after_reset", 100);
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
